// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory among NUM_REQ requesters. Only one transaction is in flight at a time.
// Best case is accept -> response valid in 3 cycles. It holds every handshake until the far side is ready, and times out to an error response.
module mem_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int CMD_WIDTH     = 1,
  parameter int TIMEOUT       = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   i_req_addr,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]       i_req_cmd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      i_req_data,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  input  logic [NUM_REQ-1:0]                 i_req_res_ready,
  output logic [NUM_REQ-1:0]                 o_req_res_valid,
  output logic [DATA_WIDTH-1:0]              o_req_data,
  output logic                               o_req_err,
  output logic                               o_mem_valid,
  output logic [ADDRESS_WIDTH-1:0]           o_mem_addr,
  output logic [CMD_WIDTH-1:0]               o_mem_cmd,
  output logic [DATA_WIDTH-1:0]              o_mem_data,
  input  logic                               i_mem_ready,
  output logic                               o_mem_res_ready,
  input  logic                               i_mem_res_valid,
  input  logic [DATA_WIDTH-1:0]              i_mem_data,
  output logic                               o_busy
);

  localparam int          IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);
  localparam bit          TMO_EN   = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [IW-1:0]            rr_last_q, rr_last_d;
  logic [IW-1:0]            gnt_q, gnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CMD_WIDTH-1:0]     cmd_q, cmd_d;
  logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]    rdat_q, rdat_d;
  logic                     err_q, err_d;
  logic                     stale_q, stale_d;
  logic [7:0]               timer_q, timer_d;

  logic                     win_vld;
  logic [IW-1:0]            win_idx;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       res_valid;
  logic                     mem_valid;
  logic                     mem_res_ready;
  logic [7:0]               timer_inc;

  // Rotating priority: search starts just after the last requester served.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_last_q) + k) % NUM_REQ;
      if (!win_vld && i_req_valid[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_last_d     = rr_last_q;
    gnt_d         = gnt_q;
    addr_d        = addr_q;
    cmd_d         = cmd_q;
    wdat_d        = wdat_q;
    rdat_d        = rdat_q;
    err_d         = err_q;
    stale_d       = stale_q;
    timer_d       = timer_q;
    req_ready     = '0;
    res_valid     = '0;
    mem_valid     = 1'b0;
    mem_res_ready = 1'b0;
    timer_inc     = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (!stale_q && win_vld) begin
          req_ready[win_idx] = 1'b1;
          gnt_d   = win_idx;
          addr_d  = i_req_addr[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          cmd_d   = i_req_cmd[int'(win_idx)*CMD_WIDTH +: CMD_WIDTH];
          wdat_d  = i_req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_valid = 1'b1;
        if (i_mem_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_res_ready = 1'b1;
        if (i_mem_res_valid) begin
          rdat_d  = i_mem_data;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          timer_d = timer_inc;
          // The abandoned response is still owed by memory; mark it for draining.
          if (TMO_EN && timer_q == TMO_LAST) begin
            rdat_d  = '0;
            err_d   = 1'b1;
            stale_d = 1'b1;
            timer_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        res_valid[gnt_q] = 1'b1;
        if (i_req_res_ready[gnt_q]) begin
          rr_last_d = gnt_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stale_q && (state_q == S_IDLE || state_q == S_RESP)) begin
      mem_res_ready = 1'b1;
      if (i_mem_res_valid) begin
        stale_d = 1'b0;
      end else begin
        timer_d = timer_inc;
        if (timer_q == TMO_LAST) stale_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rr_last_q <= IW'(NUM_REQ - 1);
      gnt_q     <= '0;
      addr_q    <= '0;
      cmd_q     <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      wdat_q    <= wdat_d;
      rdat_q    <= rdat_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      timer_q   <= timer_d;
    end
  end

  // The grant is combinational from i_req_valid, so it is gated to stay quiet while reset is held.
  assign o_req_ready     = reset ? req_ready : '0;
  assign o_req_res_valid = res_valid;
  assign o_req_data      = rdat_q;
  assign o_req_err       = err_q;
  assign o_mem_valid     = mem_valid;
  assign o_mem_addr      = addr_q;
  assign o_mem_cmd       = cmd_q;
  assign o_mem_data      = wdat_q;
  assign o_mem_res_ready = mem_res_ready;
  assign o_busy          = (state_q != S_IDLE) || stale_q;

endmodule
